mem_access_unit: RTL and testbench

- Sits directly downstream of the multi-cycle control FSM and datapath, between the core and the unified instruction/data memory.
- Converts each single-cycle core memory request (fetch, load, store) into a valid/ready bus transaction, and stalls the core while that transaction is in flight.
- Generates store byte-enables and lane replication, and sign- or zero-extends load data per funct3.
- Flags misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_access_unit_if.sv | 37 +++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core request/response and memory bus signals of mem_access_unit
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_funct3;
  logic                  req_ready;
  logic                  stall;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [3:0]            bus_be;
  logic                  bus_rvalid;
  logic [31:0]           bus_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - turns single-cycle core memory requests into valid/ready bus transactions
// Stalls the core while in flight; formats stores, extends loads, flags illegal accesses and timeouts.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave io
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic [CW-1:0]         cnt;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  req_legal;
  logic                  timeout_hit;
  logic [31:0]           load_ext;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           store_data;
  logic [3:0]            store_be;

  // Size/extension encoding plus natural alignment of the incoming request.
  always_comb begin
    req_legal = 1'b0;
    case (io.req_funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~io.req_addr[0];
      3'b010:  req_legal = (io.req_addr[1:0] == 2'b00);
      3'b100:  req_legal = ~io.req_write;
      3'b101:  req_legal = ~io.req_write & ~io.req_addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    byte_sel = io.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? io.bus_rdata[31:16] : io.bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = io.bus_rdata;
    endcase
  end

  always_comb begin
    store_data = 32'd0;
    store_be   = 4'b1111;
    if (write_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          store_data = {4{wdata_q[7:0]}};
          store_be   = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          store_data = {2{wdata_q[15:0]}};
          store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: store_data = wdata_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    io.req_ready  = 1'b0;
    io.stall      = 1'b1;
    io.resp_valid = 1'b0;
    io.bus_valid  = 1'b0;
    io.bus_we     = 1'b0;
    io.bus_addr   = '0;
    io.bus_wdata  = 32'd0;
    io.bus_be     = 4'b0000;
    case (state)
      IDLE: begin
        io.req_ready = 1'b1;
        io.stall     = 1'b0;
        if (io.req_valid) state_next = req_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        io.bus_valid = 1'b1;
        io.bus_we    = write_q;
        io.bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        io.bus_wdata = store_data;
        io.bus_be    = store_be;
        if (io.bus_ready) state_next = WAIT;
      end
      WAIT: begin
        if (io.bus_rvalid || timeout_hit) state_next = RESP;
      end
      RESP: begin
        io.resp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign io.resp_rdata = rdata_q;
  assign io.resp_err   = err_q;

  // rvalid is checked before the timeout so a same-cycle reply still succeeds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      cnt      <= '0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.req_valid) begin
            addr_q   <= io.req_addr;
            write_q  <= io.req_write;
            wdata_q  <= io.req_wdata;
            funct3_q <= io.req_funct3;
            if (!req_legal) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (io.bus_ready) cnt <= '0;
        end
        WAIT: begin
          if (io.bus_rvalid) begin
            rdata_q <= write_q ? 32'd0 : load_ext;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a behavioural reference model
module tb_mem_access_unit;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(32)) ifc ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic w, input logic [31:0] a, input logic [2:0] f3);
    int size;
    if (w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * a[1:0]);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return sh & 32'h0000_00FF;
      3'd5:    return sh & 32'h0000_FFFF;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic w, input logic [2:0] f3, input logic [31:0] wd);
    if (!w) return 32'd0;
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_be(input logic w, input logic [2:0] f3, input logic [31:0] a);
    if (!w || f3 == 3'd2) return 32'hF;
    if (f3 == 3'd0) return 32'(1 << (a % 4));
    return 32'(3 << (a % 4));
  endfunction

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                           input int rdy_dly, input int rv_dly, input logic [31:0] rd);
    logic        legal;
    logic [31:0] e_rdata;
    logic        e_err;
    int          waits;
    legal = is_legal(w, a, f3);
    @(negedge clk);
    check("req_ready_idle", 32'(ifc.req_ready), 32'd1);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = w;
    ifc.req_addr   = a;
    ifc.req_wdata  = wd;
    ifc.req_funct3 = f3;
    @(negedge clk);
    ifc.req_write  = 1'($urandom);
    ifc.req_addr   = $urandom;
    ifc.req_funct3 = 3'($urandom);
    check("stall_busy", 32'(ifc.stall), 32'd1);
    if (!legal) begin
      e_rdata = 32'd0;
      e_err   = 1'b1;
      check("illegal_bus_valid", 32'(ifc.bus_valid), 32'd0);
      check("illegal_resp_valid", 32'(ifc.resp_valid), 32'd1);
      check("illegal_resp_err", 32'(ifc.resp_err), 32'd1);
      check("illegal_resp_rdata", ifc.resp_rdata, 32'd0);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        if (k > 0) @(negedge clk);
        check("issue_bus_valid", 32'(ifc.bus_valid), 32'd1);
        check("issue_bus_addr", ifc.bus_addr, a & 32'hFFFF_FFFC);
        check("issue_bus_we", 32'(ifc.bus_we), 32'(w));
        check("issue_bus_wdata", ifc.bus_wdata, exp_wdata(w, f3, wd));
        check("issue_bus_be", 32'(ifc.bus_be), exp_be(w, f3, a));
        check("issue_stall", 32'(ifc.stall), 32'd1);
        ifc.bus_ready  = (k == rdy_dly);
        ifc.bus_rvalid = 1'($urandom);
        ifc.bus_rdata  = $urandom;
      end
      @(negedge clk);
      ifc.bus_ready = 1'b0;
      waits = 0;
      while (!ifc.resp_valid && waits < 20) begin
        check("wait_bus_valid", 32'(ifc.bus_valid), 32'd0);
        ifc.bus_rvalid = (waits == rv_dly);
        ifc.bus_rdata  = (waits == rv_dly) ? rd : $urandom;
        waits++;
        @(negedge clk);
      end
      ifc.bus_rvalid = 1'b0;
      check("wait_cycles", 32'(waits), 32'(rv_dly < TO ? rv_dly + 1 : TO));
      e_err   = (rv_dly >= TO);
      e_rdata = (e_err || w) ? 32'd0 : exp_load(f3, a, rd);
      check("resp_valid", 32'(ifc.resp_valid), 32'd1);
      check("resp_err", 32'(ifc.resp_err), 32'(e_err));
      check("resp_rdata", ifc.resp_rdata, e_rdata);
    end
    ifc.req_valid = 1'b0;
    @(negedge clk);
    ifc.bus_rvalid = 1'($urandom);
    check("resp_pulse_end", 32'(ifc.resp_valid), 32'd0);
    check("stall_released", 32'(ifc.stall), 32'd0);
    check("rdata_held", ifc.resp_rdata, e_rdata);
    check("err_held", 32'(ifc.resp_err), 32'(e_err));
  endtask

  initial begin
    reset          = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.req_write  = 1'b0;
    ifc.req_addr   = 32'd0;
    ifc.req_wdata  = 32'd0;
    ifc.req_funct3 = 3'd0;
    ifc.bus_ready  = 1'b0;
    ifc.bus_rvalid = 1'b0;
    ifc.bus_rdata  = 32'd0;
    #1;
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_stall", 32'(ifc.stall), 32'd0);
    check("rst_bus_valid", 32'(ifc.bus_valid), 32'd0);
    check("rst_bus_be", 32'(ifc.bus_be), 32'd0);
    check("rst_resp", {ifc.resp_rdata[30:0], ifc.resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_access(1'b0, 32'h103, 32'd0, 3'd0, 0, 0, 32'h80FF_1234);
    check("lb_value", ifc.resp_rdata, 32'hFFFF_FF80);
    do_access(1'b0, 32'h103, 32'd0, 3'd4, 0, 0, 32'h80FF_1234);
    check("lbu_value", ifc.resp_rdata, 32'h0000_0080);
    do_access(1'b1, 32'h202, 32'h1234_ABCD, 3'd1, 0, 2, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h101, 32'd0, 3'd2, 0, 0, 32'd0);
    do_access(1'b0, 32'h300, 32'd0, 3'd2, 5, 0, 32'hCAFE_F00D);
    do_access(1'b0, 32'h304, 32'd0, 3'd2, 0, 99, 32'h1111_2222);
    do_access(1'b0, 32'h308, 32'd0, 3'd1, 0, TO - 1, 32'h8001_7FFF);
    do_access(1'b0, 32'hFFFF_FFFC, 32'd0, 3'd2, 1, 0, 32'h7654_3210);
    do_access(1'b1, 32'h3, 32'hA5A5_A5C3, 3'd3, 0, 0, 32'd0);

    // Reset in the middle of a WAIT, then a stale rvalid that must be ignored.
    @(negedge clk);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = 1'b0;
    ifc.req_addr   = 32'h80;
    ifc.req_funct3 = 3'd2;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    ifc.bus_ready = 1'b1;
    @(negedge clk);
    ifc.bus_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_stall", 32'(ifc.stall), 32'd0);
    check("async_rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("async_rst_bus_valid", 32'(ifc.bus_valid), 32'd0);
    check("async_rst_resp_rdata", ifc.resp_rdata, 32'd0);
    @(negedge clk);
    reset          = 1'b1;
    ifc.bus_rvalid = 1'b1;
    ifc.bus_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    ifc.bus_rvalid = 1'b0;
    check("stale_rvalid_resp", 32'(ifc.resp_valid), 32'd0);
    check("stale_rvalid_idle", 32'(ifc.req_ready), 32'd1);
    do_access(1'b0, 32'h40, 32'd0, 3'd2, 0, 1, 32'h0BAD_CAFE);
    check("post_reset_lw", ifc.resp_rdata, 32'h0BAD_CAFE);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom % 4 == 0) ? 32'hFFFF_FFFC | ($urandom % 4) : $urandom;
      do_access(1'($urandom), a, $urandom, 3'($urandom), $urandom % 4, $urandom % 10, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
